// File: rtl/wr_addr_gen_if.sv
// Signal bundle between acquisition control and the DDR write address generator.
// The controller holds the master side; the address generator holds the slave side.
interface wr_addr_gen_if #(
  parameter int BIT_CNT = 27,
  parameter int ADDR_W  = 28
);
  logic [3:0]         DIMMdepth_ctrl;
  logic               arm;
  logic               wr_en;
  logic               trig;
  logic [ADDR_W-1:0]  pre_num;
  logic [ADDR_W-1:0]  post_num;
  logic [ADDR_W-1:0]  addr_wr_out;
  logic               syn_en_addr;
  logic [ADDR_W-1:0]  trig_addr;
  logic [ADDR_W:0]    start_addr_rd;
  logic [BIT_CNT-1:0] cnt_num_wr;
  logic               wr_busy;
  logic               wr_done;

  modport master (
    output DIMMdepth_ctrl, arm, wr_en, trig, pre_num, post_num,
    input  addr_wr_out, syn_en_addr, trig_addr, start_addr_rd, cnt_num_wr, wr_busy, wr_done
  );

  modport slave (
    input  DIMMdepth_ctrl, arm, wr_en, trig, pre_num, post_num,
    output addr_wr_out, syn_en_addr, trig_addr, start_addr_rd, cnt_num_wr, wr_busy, wr_done
  );
endinterface

// File: rtl/wr_addr_gen.sv
// DDR write address generator for the capture buffer: counts 128-bit beats into a circular
// region, strobes one 512-bit burst command per 4 beats, and runs the pre/trigger/post sequence.
module wr_addr_gen #(
  parameter int BIT_CNT = 27,
  parameter int ADDR_W  = 28
) (
  input  logic          clk,
  input  logic          rst,
  wr_addr_gen_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_e;

  state_e             state_q;
  logic [3:0]         depth_q;
  logic [BIT_CNT-1:0] cnt_num_q;
  logic [BIT_CNT-1:0] cnt_num_d;
  logic [ADDR_W-1:0]  pre_cnt_q;
  logic [ADDR_W-1:0]  post_cnt_q;
  logic [ADDR_W-1:0]  addr_wr_q;
  logic [ADDR_W-1:0]  trig_addr_q;
  logic [ADDR_W:0]    start_addr_q;
  logic               syn_en_q;
  logic               busy_q;
  logic               done_q;

  logic [ADDR_W-1:0]  mask;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  burst_addr;
  logic [ADDR_W-1:0]  start_d;
  logic               beat;
  logic               burst_end;
  logic               pre_reached;
  logic               post_reached;

  // Depth code selects how many low address bits survive; the rest fold the buffer.
  function automatic logic [ADDR_W-1:0] depth_mask(input logic [3:0] code);
    int unsigned n;
    case (code)
      4'b1111: n = 28;
      4'b1110: n = 27;
      4'b1101: n = 26;
      4'b1100: n = 25;
      4'b1011: n = 24;
      4'b1010: n = 23;
      4'b1001: n = 22;
      4'b1000: n = 21;
      4'b0111: n = 20;
      4'b0110: n = 19;
      4'b0101: n = 17;
      4'b0100: n = 16;
      4'b0011: n = 14;
      4'b0010: n = 12;
      4'b0001: n = 10;
      4'b0000: n = 8;
      default: n = 20;
    endcase
    return ~({ADDR_W{1'b1}} << n);
  endfunction

  // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
  always_comb begin
    mask         = depth_mask(depth_q);
    beat         = (state_q inside {S_PRE, S_ARMED, S_POST}) && bus.wr_en;
    cnt_num_d    = cnt_num_q + {{(BIT_CNT-1){1'b0}}, beat};
    burst_end    = beat && (cnt_num_q[1:0] == 2'b11);
    cur_addr     = {cnt_num_q, 1'b0} & mask;
    burst_addr   = {cnt_num_q[BIT_CNT-1:2], 3'b000} & mask;
    start_d      = ({cnt_num_q, 1'b0} - {bus.pre_num[ADDR_W-2:0], 1'b0}) & mask;
    pre_reached  = ({1'b0, pre_cnt_q} + {{ADDR_W{1'b0}}, beat}) >= {1'b0, bus.pre_num};
    post_reached = ({1'b0, post_cnt_q} + {{ADDR_W{1'b0}}, 1'b1}) >= {1'b0, bus.post_num};
  end

  // NOTE: all state uses non-blocking assignments; a later assignment in the same cycle overrides an earlier one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      depth_q      <= '0;
      cnt_num_q    <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      addr_wr_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      syn_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      depth_q   <= bus.DIMMdepth_ctrl;
      cnt_num_q <= cnt_num_d;
      syn_en_q  <= burst_end;
      if (burst_end) addr_wr_q <= burst_addr;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.arm) begin
            state_q    <= S_PRE;
            cnt_num_q  <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_PRE: begin
          pre_cnt_q <= pre_cnt_q + {{(ADDR_W-1){1'b0}}, beat};
          if (pre_reached) state_q <= S_ARMED;
        end
        S_ARMED: begin
          // The beat written on the trigger cycle is the first post-trigger beat.
          if (bus.trig) begin
            trig_addr_q  <= cur_addr;
            start_addr_q <= {1'b0, start_d};
            post_cnt_q   <= {{(ADDR_W-1){1'b0}}, beat};
            state_q      <= S_POST;
          end
        end
        S_POST: begin
          if (beat) begin
            post_cnt_q <= post_cnt_q + 1'b1;
            if (post_reached && (cnt_num_q[1:0] == 2'b11)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.addr_wr_out   = addr_wr_q;
  assign bus.syn_en_addr   = syn_en_q;
  assign bus.trig_addr     = trig_addr_q;
  assign bus.start_addr_rd = start_addr_q;
  assign bus.cnt_num_wr    = cnt_num_q;
  assign bus.wr_busy       = busy_q;
  assign bus.wr_done       = done_q;

endmodule

// File: tb/tb_wr_addr_gen.sv
// Bench for wr_addr_gen: a beat-count model checked every cycle, directed scenarios with
// hand-derived literals, then randomized acquisitions with random arm, trigger and reset.
module tb_wr_addr_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wr_addr_gen_if bus ();

  wr_addr_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 pre, 2 armed, 3 post, 4 done. Positions are absolute beat counts since arm.
  int                  m_phase = 0;
  longint unsigned     m_beats = 0;
  longint unsigned     m_pre   = 0;
  longint unsigned     m_post  = 0;
  logic [3:0]          m_depth = '0;
  logic [63:0]         e_addr  = '0;
  logic [63:0]         e_trig  = '0;
  logic [63:0]         e_start = '0;
  bit                  e_syn   = 1'b0;
  bit                  e_busy  = 1'b0;
  bit                  e_done  = 1'b0;
  bit                  model_live = 1'b0;

  function automatic logic [63:0] mask_of(input logic [3:0] code);
    int bits [16];
    bits = '{8, 10, 12, 14, 16, 17, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28};
    return (64'd1 << bits[code]) - 64'd1;
  endfunction

  always @(posedge clk) begin
    logic [63:0] mask;
    bit acc;
    if (rst) begin
      m_phase = 0; m_beats = 0; m_pre = 0; m_post = 0; m_depth = '0;
      e_addr = '0; e_trig = '0; e_start = '0; e_syn = 1'b0;
      model_live = 1'b1;
    end else begin
      mask    = mask_of(m_depth);
      m_depth = bus.DIMMdepth_ctrl;
      acc     = bus.wr_en && (m_phase >= 1) && (m_phase <= 3);
      // A burst completes on every 4th beat; its base is burst index * 8 address units.
      e_syn   = acc && (m_beats % 4 == 3);
      if (e_syn) e_addr = ((m_beats / 4) * 8) & mask;
      case (m_phase)
        0, 4: if (bus.arm) begin
          m_phase = 1; m_beats = 0; m_pre = 0; m_post = 0;
        end
        1: begin
          if (acc) m_pre++;
          if (m_pre >= 64'(bus.pre_num)) m_phase = 2;
        end
        2: if (bus.trig) begin
          e_trig  = (2 * m_beats) & mask;
          e_start = (2 * m_beats + (64'd1 << 29) - 2 * 64'(bus.pre_num)) & mask;
          m_post  = acc ? 1 : 0;
          m_phase = 3;
        end
        3: if (acc) begin
          m_post++;
          if (m_post >= 64'(bus.post_num) && (m_beats % 4 == 3)) m_phase = 4;
        end
        default: m_phase = 0;
      endcase
      if (acc) m_beats++;
    end
    e_busy = (m_phase >= 1) && (m_phase <= 3);
    e_done = (m_phase == 4);
  end

  // One compare process: every output, every cycle, on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("addr_wr_out",   64'(bus.addr_wr_out),   e_addr);
      check("syn_en_addr",   64'(bus.syn_en_addr),   64'(e_syn));
      check("trig_addr",     64'(bus.trig_addr),     e_trig);
      check("start_addr_rd", 64'(bus.start_addr_rd), e_start);
      check("cnt_num_wr",    64'(bus.cnt_num_wr),    m_beats & 64'h7FF_FFFF);
      check("wr_busy",       64'(bus.wr_busy),       64'(e_busy));
      check("wr_done",       64'(bus.wr_done),       64'(e_done));
    end
  end

  // Collected burst bases, used by the directed literal checks.
  logic [63:0] strobes [$];
  always @(negedge clk) begin
    if (bus.syn_en_addr === 1'b1) strobes.push_back(64'(bus.addr_wr_out));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit a, input bit w, input bit t);
    bus.arm = a; bus.wr_en = w; bus.trig = t;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic setup(input logic [3:0] d, input int pre, input int post);
    rst = 1'b1;
    bus.DIMMdepth_ctrl = d; bus.pre_num = 28'(pre); bus.post_num = 28'(post);
    idle(2);
    rst = 1'b0;
    idle(3);
    strobes.delete();
  endtask

  // n beats, `gap` idle cycles before each; trig pulses on beat trig_beat (1-based) or is held.
  task automatic run(input int n, input int gap, input int trig_beat, input bit hold);
    for (int k = 1; k <= n; k++) begin
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, hold);
      cyc(1'b0, 1'b1, hold || (k == trig_beat));
    end
  endtask

  task automatic check_strobe(input string name, input int idx, input logic [63:0] exp);
    if (idx < strobes.size()) check(name, strobes[idx], exp);
    else check(name, 64'hDEAD_0000 + 64'(strobes.size()), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] q_cont [$];
    bus.arm = 1'b0; bus.wr_en = 1'b0; bus.trig = 1'b0;
    bus.DIMMdepth_ctrl = 4'd0; bus.pre_num = '0; bus.post_num = '0;
    @(posedge clk); #2;
    idle(2);

    // Reset state
    check("reset addr_wr_out", 64'(bus.addr_wr_out), 64'h0);
    check("reset wr_busy", 64'(bus.wr_busy), 64'h0);
    check("reset cnt_num_wr", 64'(bus.cnt_num_wr), 64'h0);

    // T1: 8-bit buffer, continuous beats, burst bases step by 8 and wrap at 0x100
    setup(4'b0000, 0, 1000);
    cyc(1'b1, 1'b0, 1'b0);
    run(200, 0, 0, 1'b0);
    idle(2);
    check("T1 strobe count", 64'(strobes.size()), 64'd50);
    check_strobe("T1 strobe 0", 0, 64'h000);
    check_strobe("T1 strobe 1", 1, 64'h008);
    check_strobe("T1 strobe 31", 31, 64'h0F8);
    check_strobe("T1 strobe 32 wrap", 32, 64'h000);
    check_strobe("T1 strobe 49", 49, 64'h088);

    // T2: trigger held from arm is only honoured after 8 pre-trigger beats
    setup(4'b0000, 8, 1000);
    cyc(1'b1, 1'b0, 1'b1);
    run(12, 0, 0, 1'b1);
    idle(2);
    check("T2 trig_addr", 64'(bus.trig_addr), 64'h010);
    check("T2 start_addr_rd", 64'(bus.start_addr_rd), 64'h000);

    // T3: full depth, pre 4, post 6, trigger on beat 10 -> done after beat 16
    setup(4'b1111, 4, 6);
    cyc(1'b1, 1'b0, 1'b0);
    run(20, 0, 10, 1'b0);
    idle(2);
    check("T3 trig_addr", 64'(bus.trig_addr), 64'h012);
    check("T3 start_addr_rd", 64'(bus.start_addr_rd), 64'h00A);
    check("T3 wr_done", 64'(bus.wr_done), 64'h1);
    check("T3 wr_busy", 64'(bus.wr_busy), 64'h0);
    check("T3 cnt_num_wr", 64'(bus.cnt_num_wr), 64'd16);
    check("T3 strobe count", 64'(strobes.size()), 64'd4);
    check_strobe("T3 last strobe", 3, 64'h018);

    // T4: gapped beats give the same bursts as continuous ones
    setup(4'b1111, 4, 8);
    cyc(1'b1, 1'b0, 1'b0);
    run(30, 0, 10, 1'b0);
    idle(2);
    q_cont = strobes;
    check("T4 continuous strobe count", 64'(q_cont.size()), 64'd5);
    check_strobe("T4 continuous last strobe", 4, 64'h020);
    setup(4'b1111, 4, 8);
    cyc(1'b1, 1'b0, 1'b0);
    run(30, 2, 10, 1'b0);
    idle(2);
    check("T4 gapped strobe count", 64'(strobes.size()), 64'(q_cont.size()));
    for (int i = 0; i < q_cont.size(); i++) check_strobe($sformatf("T4 gapped strobe %0d", i), i, q_cont[i]);

    // T5: arm in POST ignored; reset in POST kills a pending strobe; re-arm restarts at 0
    setup(4'b0000, 0, 100);
    cyc(1'b1, 1'b0, 1'b0);
    run(10, 0, 6, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("T5 busy after arm in POST", 64'(bus.wr_busy), 64'h1);
    check("T5 cnt after arm in POST", 64'(bus.cnt_num_wr), 64'd11);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    strobes.delete();
    check("T5 rst syn_en_addr", 64'(bus.syn_en_addr), 64'h0);
    check("T5 rst addr_wr_out", 64'(bus.addr_wr_out), 64'h0);
    check("T5 rst trig_addr", 64'(bus.trig_addr), 64'h0);
    check("T5 rst start_addr_rd", 64'(bus.start_addr_rd), 64'h0);
    check("T5 rst cnt_num_wr", 64'(bus.cnt_num_wr), 64'h0);
    check("T5 rst wr_busy", 64'(bus.wr_busy), 64'h0);
    rst = 1'b0;
    idle(1);
    cyc(1'b1, 1'b0, 1'b0);
    run(4, 0, 0, 1'b0);
    idle(2);
    check("T5 restart strobe count", 64'(strobes.size()), 64'd1);
    check_strobe("T5 restart strobe addr", 0, 64'h000);

    // T6: 4K buffer with 2048 pre beats wraps to 0; start address folds into 12 bits
    setup(4'b0010, 2048, 1000);
    cyc(1'b1, 1'b0, 1'b0);
    run(2104, 0, 2101, 1'b0);
    idle(2);
    check_strobe("T6 strobe before wrap", 511, 64'hFF8);
    check_strobe("T6 strobe at wrap", 512, 64'h000);
    check("T6 trig_addr", 64'(bus.trig_addr), 64'h068);
    check("T6 start_addr_rd", 64'(bus.start_addr_rd), 64'h068);

    // Randomized acquisitions: model-checked every cycle
    for (int s = 0; s < 10; s++) begin
      int den;
      setup(4'($urandom_range(0, 15)), int'($urandom_range(0, 300)), int'($urandom_range(0, 120)));
      den = int'($urandom_range(1, 4));
      cyc(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 700; c++) begin
        rst = ($urandom_range(0, 899) == 0);
        cyc($urandom_range(0, 149) == 0, $urandom_range(0, den - 1) == 0, $urandom_range(0, 39) == 0);
        rst = 1'b0;
      end
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
